// File: rtl/cnn_defs_pkg.sv
// Shared defaults and FSM encodings for the CNN line-buffer front end.
package cnn_defs;
    localparam int DATA_WIDTH_DEF = 16;
    localparam int MAP_WIDTH_DEF  = 28;
    localparam int MAP_HEIGHT_DEF = 28;
    localparam int FILL_ROWS      = 4;

    typedef enum logic [0:0] {
        ST_FILL   = 1'b0,
        ST_STREAM = 1'b1
    } lb_state_e;

    // Row-memory index k rows newer than the oldest one; wraps modulo 4.
    function automatic logic [1:0] ptr_add(input logic [1:0] ptr, input logic [1:0] k);
        return ptr + k;
    endfunction
endpackage

// File: rtl/line_ram.sv
// Single-clock simple dual-port row memory: synchronous write, combinational read.
module line_ram #(
    parameter int data_width = 16,
    parameter int depth      = 28,
    parameter int addr_width = $clog2(depth)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);
    logic [data_width-1:0] mem_r [depth];

    // Write port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];
endmodule

// File: rtl/line_buffer_5row.sv
// Five-row line buffer emitting vertical pixel columns for a 5x5 convolution.
// Optional status outputs (row_idx, col_idx, frame_done) with LINE_BUF_STATUS_EN.
module line_buffer_5row
    import cnn_defs::*;
#(
    parameter int data_width = DATA_WIDTH_DEF,
    parameter int map_width  = MAP_WIDTH_DEF,
    parameter int map_height = MAP_HEIGHT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [data_width-1:0] din,
    input  logic                  din_valid,
    input  logic                  sof,
    output logic [data_width-1:0] d_out1,
    output logic [data_width-1:0] d_out2,
    output logic [data_width-1:0] d_out3,
    output logic [data_width-1:0] d_out4,
    output logic [data_width-1:0] d_out5,
    output logic                  out_valid
`ifdef LINE_BUF_STATUS_EN
    ,
    output logic [$clog2(map_height)-1:0] row_idx,
    output logic [$clog2(map_width)-1:0]  col_idx,
    output logic                          frame_done
`endif
);
    localparam int COL_W = $clog2(map_width);
    localparam int ROW_W = $clog2(map_height);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(map_width - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(map_height - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(FILL_ROWS);

    lb_state_e              state_r, state_nxt_s;
    logic [COL_W-1:0]       col_cnt_r, col_nxt_s, eff_col_s;
    logic [ROW_W-1:0]       row_cnt_r, row_nxt_s, eff_row_s;
    logic [1:0]             ptr_r, ptr_nxt_s;
    logic                   stream_pix_s;
    logic                   frame_last_s;
    logic [data_width-1:0]  rd_s [4];
    logic                   we_s [4];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_rows
            assign we_s[g] = din_valid & (ptr_r == 2'(g));
            line_ram #(
                .data_width(data_width),
                .depth     (map_width),
                .addr_width(COL_W)
            ) u_ram (
                .clk  (clk),
                .we   (we_s[g]),
                .waddr(eff_col_s),
                .wdata(din),
                .raddr(eff_col_s),
                .rdata(rd_s[g])
            );
        end
    endgenerate

    // Pixel position, counter advance, FSM next state and output qualification.
    always_comb begin
        state_nxt_s  = state_r;
        eff_col_s    = col_cnt_r;
        eff_row_s    = row_cnt_r;
        col_nxt_s    = col_cnt_r;
        row_nxt_s    = row_cnt_r;
        ptr_nxt_s    = ptr_r;
        stream_pix_s = 1'b0;
        frame_last_s = 1'b0;
        if (din_valid) begin
            // sof relocates this very pixel to the frame origin
            if (sof) begin
                eff_col_s = '0;
                eff_row_s = '0;
            end else begin
                eff_col_s = col_cnt_r;
                eff_row_s = row_cnt_r;
            end
            if (eff_col_s == COL_LAST) begin
                col_nxt_s = '0;
                ptr_nxt_s = ptr_add(ptr_r, 2'd1);
                if (eff_row_s == ROW_LAST) begin
                    row_nxt_s    = '0;
                    frame_last_s = 1'b1;
                end else begin
                    row_nxt_s = eff_row_s + ROW_W'(1);
                end
            end else begin
                col_nxt_s = eff_col_s + COL_W'(1);
                row_nxt_s = eff_row_s;
            end
            stream_pix_s = !sof && ((state_r == ST_STREAM) || (eff_row_s == ROW_FIRST));
            if (frame_last_s || sof) begin
                state_nxt_s = ST_FILL;
            end else begin
                case (state_r)
                    ST_FILL:   state_nxt_s = (eff_row_s == ROW_FIRST) ? ST_STREAM : ST_FILL;
                    ST_STREAM: state_nxt_s = ST_STREAM;
                    default:   state_nxt_s = ST_FILL;
                endcase
            end
        end else begin
            state_nxt_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Column/row counters and oldest-row pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_r <= '0;
            row_cnt_r <= '0;
            ptr_r     <= 2'd0;
        end else begin
            col_cnt_r <= col_nxt_s;
            row_cnt_r <= row_nxt_s;
            ptr_r     <= ptr_nxt_s;
        end
    end

    // Registered column output; data holds while no column is emitted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out1    <= '0;
            d_out2    <= '0;
            d_out3    <= '0;
            d_out4    <= '0;
            d_out5    <= '0;
            out_valid <= 1'b0;
        end else if (stream_pix_s) begin
            d_out1    <= rd_s[ptr_r];
            d_out2    <= rd_s[ptr_add(ptr_r, 2'd1)];
            d_out3    <= rd_s[ptr_add(ptr_r, 2'd2)];
            d_out4    <= rd_s[ptr_add(ptr_r, 2'd3)];
            d_out5    <= din;
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

`ifdef LINE_BUF_STATUS_EN
    // Position of the emitted column and end-of-frame marker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_idx    <= '0;
            col_idx    <= '0;
            frame_done <= 1'b0;
        end else if (stream_pix_s) begin
            row_idx    <= eff_row_s;
            col_idx    <= eff_col_s;
            frame_done <= frame_last_s;
        end else begin
            frame_done <= 1'b0;
        end
    end
`endif
endmodule
